sd_card_dat_responder: RTL and testbench

SD_CARD_DAT_RESPONDER -- requirements
Module: sd_card_dat_responder

---
 rtl/sd_card_dat_responder_if.sv | 40 ++++
 rtl/sd_card_dat_responder.sv | 174 +++++++++++++++++
 tb/tb_sd_card_dat_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_card_dat_responder_if.sv
// DAT0 bus bundle between an SD host and the card-side write-data responder.
// The card connects through the slave modport and the host or bench through master.
interface sd_card_dat_responder_if;
  logic        enable;
  logic        dat_in;
  logic        dat_out;
  logic        dat_oe;
  logic [31:0] data_word;
  logic        word_valid;
  logic        block_done;
  logic        crc_ok;
  logic        frame_err;
  logic        busy;

  modport master (
    output enable,
    output dat_in,
    input  dat_out,
    input  dat_oe,
    input  data_word,
    input  word_valid,
    input  block_done,
    input  crc_ok,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  enable,
    input  dat_in,
    output dat_out,
    output dat_oe,
    output data_word,
    output word_valid,
    output block_done,
    output crc_ok,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/sd_card_dat_responder.sv
// Card-side DAT0 write responder: receives a data block with its CRC16,
// then answers with an Ncrc gap, a CRC status token and a busy period.
module sd_card_dat_responder #(
  parameter int BLOCK_WORDS = 1,
  parameter int BUSY_CYCLES = 8,
  parameter int NCRC        = 2
) (
  input  logic                   sd_clock,
  input  logic                   reset,
  sd_card_dat_responder_if.slave bus
);

  localparam int DATA_BITS = 32 * BLOCK_WORDS;
  localparam int MAX_AB    = (DATA_BITS > BUSY_CYCLES) ? DATA_BITS : BUSY_CYCLES;
  localparam int CNT_MAX   = (MAX_AB > NCRC) ? MAX_AB : NCRC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int NCRC_LAST = (NCRC > 0) ? NCRC - 1 : 0;
  localparam int BUSY_LAST = (BUSY_CYCLES > 0) ? BUSY_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE,
    RX_DATA,
    RX_CRC,
    RX_END,
    WAIT_NCRC,
    TX_TOKEN,
    BUSY
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [30:0]      shreg;
  logic [15:0]      crc_calc;
  logic [14:0]      crc_rx;
  logic [31:0]      data_word;
  logic             word_valid;
  logic             block_done;
  logic             crc_ok;
  logic             frame_err;
  logic             dat_oe;
  logic             dat_out;
  logic             busy;
  logic [4:0]       token;
  logic [2:0]       tok_idx;
  logic             start_bit;
  logic             last_data;
  logic             last_crc;
  logic             last_ncrc;
  logic             last_tok;
  logic             last_busy;

  // CRC16-CCITT step (x^16+x^12+x^5+1), one bit in, MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign start_bit = bus.enable && !bus.dat_in;
  assign last_data = (cnt == CNT_W'(DATA_BITS - 1));
  assign last_crc  = (cnt == CNT_W'(15));
  assign last_ncrc = (cnt == CNT_W'(NCRC_LAST));
  assign last_tok  = (cnt == CNT_W'(4));
  assign last_busy = (cnt == CNT_W'(BUSY_LAST));

  // Token is sent MSB first: start 0, status 010 (good) or 101 (bad), end 1.
  assign token   = {1'b0, (crc_ok ? 3'b010 : 3'b101), 1'b1};
  assign tok_idx = 3'd4 - cnt[2:0];

  always_comb begin
    state_nxt = state;
    dat_oe    = 1'b0;
    dat_out   = 1'b1;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start_bit) state_nxt = RX_DATA;
      end
      RX_DATA: begin
        if (last_data) state_nxt = RX_CRC;
      end
      RX_CRC: begin
        if (last_crc) state_nxt = RX_END;
      end
      RX_END: begin
        if (bus.dat_in) state_nxt = (NCRC > 0) ? WAIT_NCRC : TX_TOKEN;
        else            state_nxt = IDLE;
      end
      WAIT_NCRC: begin
        if (last_ncrc) state_nxt = TX_TOKEN;
      end
      TX_TOKEN: begin
        dat_oe  = 1'b1;
        dat_out = token[tok_idx];
        busy    = 1'b1;
        if (last_tok) state_nxt = (BUSY_CYCLES > 0) ? BUSY : IDLE;
      end
      BUSY: begin
        dat_oe  = 1'b1;
        dat_out = 1'b0;
        busy    = 1'b1;
        if (last_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      crc_calc   <= '0;
      crc_rx     <= '0;
      data_word  <= '0;
      word_valid <= 1'b0;
      block_done <= 1'b0;
      crc_ok     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_valid <= 1'b0;
      block_done <= 1'b0;
      frame_err  <= 1'b0;
      // One shared counter restarts on every state change.
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start_bit) begin
            crc_calc <= '0;
            crc_ok   <= 1'b0;
          end
        end
        RX_DATA: begin
          shreg    <= {shreg[29:0], bus.dat_in};
          crc_calc <= crc16_step(crc_calc, bus.dat_in);
          if (cnt[4:0] == 5'd31) begin
            data_word  <= {shreg, bus.dat_in};
            word_valid <= 1'b1;
          end
        end
        RX_CRC: begin
          crc_rx <= {crc_rx[13:0], bus.dat_in};
          if (last_crc) crc_ok <= ({crc_rx, bus.dat_in} == crc_calc);
        end
        RX_END: begin
          if (!bus.dat_in) begin
            frame_err  <= 1'b1;
            block_done <= 1'b1;
          end
        end
        TX_TOKEN: begin
          if (last_tok && BUSY_CYCLES == 0) block_done <= 1'b1;
        end
        BUSY: begin
          if (last_busy) block_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.dat_out    = dat_out;
  assign bus.dat_oe     = dat_oe;
  assign bus.busy       = busy;
  assign bus.data_word  = data_word;
  assign bus.word_valid = word_valid;
  assign bus.block_done = block_done;
  assign bus.crc_ok     = crc_ok;
  assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_sd_card_dat_responder.sv
// Bench for sd_card_dat_responder: a one-word and a two-word instance driven
// through a shared host model, checked against a CRC long-division reference.
module tb_sd_card_dat_responder;
  localparam int NCRC_T = 2;
  localparam int BUSY_T = 8;

  logic clk;
  logic rst;
  logic en;
  logic din;
  logic sel;
  int   n_cmp;
  int   n_bad;

  sd_card_dat_responder_if bus1 ();
  sd_card_dat_responder_if bus2 ();

  assign bus1.enable = en;
  assign bus2.enable = en;
  assign bus1.dat_in = sel ? 1'b1 : din;
  assign bus2.dat_in = sel ? din : 1'b1;

  sd_card_dat_responder #(.BLOCK_WORDS(1), .BUSY_CYCLES(BUSY_T), .NCRC(NCRC_T)) dut1 (
    .sd_clock(clk), .reset(rst), .bus(bus1));
  sd_card_dat_responder #(.BLOCK_WORDS(2), .BUSY_CYCLES(BUSY_T), .NCRC(NCRC_T)) dut2 (
    .sd_clock(clk), .reset(rst), .bus(bus2));

  logic        o_oe, o_out, o_wv, o_bd, o_ok, o_fe, o_busy;
  logic [31:0] o_dw;
  assign o_oe   = sel ? bus2.dat_oe     : bus1.dat_oe;
  assign o_out  = sel ? bus2.dat_out    : bus1.dat_out;
  assign o_wv   = sel ? bus2.word_valid : bus1.word_valid;
  assign o_bd   = sel ? bus2.block_done : bus1.block_done;
  assign o_ok   = sel ? bus2.crc_ok     : bus1.crc_ok;
  assign o_fe   = sel ? bus2.frame_err  : bus1.frame_err;
  assign o_busy = sel ? bus2.busy       : bus1.busy;
  assign o_dw   = sel ? bus2.data_word  : bus1.data_word;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    #1;
  endtask

  // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] crc_ref(input logic [63:0] m, input int n);
    logic [16:0] rem;
    logic        b;
    rem = '0;
    for (int i = 0; i < n + 16; i++) begin
      b   = (i < n) ? m[n-1-i] : 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_dat_oe", o_oe, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_dat_out", o_out, 1);
    chk("rst_crc_ok", o_ok, 0);
    chk("rst_data_word", o_dw, 0);
    chk("rst_block_done", o_bd, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_block(input bit use2, input logic [31:0] w0, input logic [31:0] w1,
                            input bit flip, input bit end_bit, input bit drop_en,
                            input int rst_at);
    int          n;
    int          k;
    int          len;
    logic [63:0] msg;
    logic [15:0] crc_tx;
    logic        ok_exp;
    logic [31:0] wexp;
    logic [4:0]  tok;
    logic        exp_oe[$];
    logic        exp_out[$];
    sel    = use2;
    n      = use2 ? 64 : 32;
    msg    = use2 ? {w0, w1} : {32'h0, w0};
    crc_tx = crc_ref(msg, n);
    if (flip) begin
      k = int'($urandom_range(15, 0));
      crc_tx[k] = ~crc_tx[k];
    end
    ok_exp = !flip;
    tick(1'b0);
    if (drop_en) en = 1'b0;
    for (int j = 0; j < n; j++) begin
      tick(msg[n-1-j]);
      if (j == 0) begin
        chk("crc_ok_cleared", o_ok, 0);
        chk("dat_oe_rx", o_oe, 0);
      end
      chk("word_valid", o_wv, ((j % 32) == 31) ? 1 : 0);
      if ((j % 32) == 31) begin
        wexp = (j < 32) ? w0 : w1;
        chk("data_word", o_dw, wexp);
      end
    end
    for (int i = 15; i >= 0; i--) tick(crc_tx[i]);
    chk("crc_ok", o_ok, ok_exp);
    tick(end_bit);
    if (!end_bit) begin
      chk("frame_err", o_fe, 1);
      chk("block_done_fe", o_bd, 1);
      chk("dat_oe_fe", o_oe, 0);
      tick(1'b1);
      chk("frame_err_pulse", o_fe, 0);
      chk("block_done_pulse_fe", o_bd, 0);
      chk("dat_oe_fe2", o_oe, 0);
      chk("dat_out_fe2", o_out, 1);
      tick(1'b1);
      chk("dat_oe_fe3", o_oe, 0);
    end else begin
      tok = ok_exp ? 5'b00101 : 5'b01011;
      for (int i = 0; i < NCRC_T; i++) begin exp_oe.push_back(1'b0); exp_out.push_back(1'b1); end
      for (int i = 0; i < 5; i++)      begin exp_oe.push_back(1'b1); exp_out.push_back(tok[4-i]); end
      for (int i = 0; i < BUSY_T; i++) begin exp_oe.push_back(1'b1); exp_out.push_back(1'b0); end
      len = NCRC_T + 5 + BUSY_T;
      chk("frame_err_ok", o_fe, 0);
      for (int idx = 0; idx < len; idx++) begin
        if (idx > 0) begin
          if (idx == rst_at) begin
            do_reset();
            en = 1'b1;
            return;
          end
          tick(($urandom_range(1, 0) == 1) ? 1'b1 : 1'b0);
        end
        chk("dat_oe", o_oe, exp_oe[idx]);
        chk("dat_out", o_out, exp_out[idx]);
        chk("busy", o_busy, (idx >= NCRC_T) ? 1 : 0);
        chk("block_done_early", o_bd, 0);
      end
      tick(($urandom_range(1, 0) == 1) ? 1'b1 : 1'b0);
      chk("block_done", o_bd, 1);
      chk("dat_oe_end", o_oe, 0);
      chk("busy_end", o_busy, 0);
      chk("dat_out_end", o_out, 1);
      tick(1'b1);
      chk("block_done_pulse", o_bd, 0);
      chk("crc_ok_held", o_ok, ok_exp);
    end
    en = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sel   = 1'b0;
    en    = 1'b1;
    din   = 1'b1;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_dat_oe", o_oe, 0);
    chk("init_dat_out", o_out, 1);
    chk("init_word_valid", o_wv, 0);
    chk("init_block_done", o_bd, 0);
    chk("init_crc_ok", o_ok, 0);
    chk("init_frame_err", o_fe, 0);
    chk("init_busy", o_busy, 0);
    chk("init_data_word", o_dw, 0);
    @(negedge clk);
    rst = 1'b0;

    send_block(1'b0, 32'hAB45FEDC, 32'h0, 1'b0, 1'b1, 1'b0, -1);
    send_block(1'b0, 32'hAB45FEDC, 32'h0, 1'b1, 1'b1, 1'b0, -1);
    send_block(1'b0, 32'h5A5AC3C3, 32'h0, 1'b0, 1'b0, 1'b0, -1);
    send_block(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b0, -1);

    sel = 1'b0;
    en  = 1'b0;
    tick(1'b0);
    for (int i = 0; i < 70; i++) begin
      tick(($urandom_range(1, 0) == 1) ? 1'b1 : 1'b0);
      chk("en_low_word_valid", o_wv, 0);
      chk("en_low_dat_oe", o_oe, 0);
      chk("en_low_busy", o_busy, 0);
    end
    din = 1'b1;
    en  = 1'b1;
    tick(1'b1);

    send_block(1'b0, $urandom, 32'h0, 1'b0, 1'b1, 1'b1, -1);

    for (int r = 0; r < 12; r++) begin
      send_block(($urandom_range(1, 0) == 1), $urandom, $urandom,
                 ($urandom_range(2, 0) == 0), ($urandom_range(3, 0) != 0),
                 ($urandom_range(1, 0) == 1), -1);
    end

    send_block(1'b0, $urandom, 32'h0, 1'b0, 1'b1, 1'b0, NCRC_T + 5 + 3);
    tick(1'b1);
    chk("post_rst_dat_oe", o_oe, 0);
    send_block(1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
